// File: rtl/alu_op_queue_if.sv
// Producer-side and ALU-side handshake bundle for the operand/opcode issue queue.
// The queue uses the slave view; the producer/ALU harness uses the master view.
interface alu_op_queue_if #(
  parameter int DATA_W = 8,
  parameter int INST_W = 3
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_a_i;
  logic [DATA_W-1:0] in_b_i;
  logic [INST_W-1:0] in_inst_i;
  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [DATA_W-1:0] data_a_o;
  logic [DATA_W-1:0] data_b_o;
  logic [INST_W-1:0] inst_o;

  modport master (
    output in_valid_i, in_a_i, in_b_i, in_inst_i, issue_ready_i,
    input  in_ready_o, issue_valid_o, data_a_o, data_b_o, inst_o
  );

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, in_inst_i, issue_ready_i,
    output in_ready_o, issue_valid_o, data_a_o, data_b_o, inst_o
  );
endinterface

// File: rtl/alu_op_queue.sv
// Issue queue ahead of the ALU: buffers {data_a, data_b, inst} and presents the oldest entry.
// Full/empty come from the occupancy count so pointers can wrap freely.
module alu_op_queue #(
  parameter int  DATA_W = 8,
  parameter int  INST_W = 3,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               flush_i,
  alu_op_queue_if.slave      bus,
  output logic [CNT_W-1:0]   count_o,
  output logic               ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop in the same cycle never frees room for a push while full.
  assign push  = bus.in_valid_i && !full;
  assign pop   = !empty && bus.issue_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (bus.in_valid_i && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst_i && !flush_i && push) begin
      mem_q[wr_ptr_q] <= '{a: bus.in_a_i, b: bus.in_b_i, inst: bus.in_inst_i};
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign bus.in_ready_o    = !full;
  assign bus.issue_valid_o = !empty;
  assign bus.data_a_o      = empty ? '0 : head.a;
  assign bus.data_b_o      = empty ? '0 : head.b;
  assign bus.inst_o        = empty ? '0 : head.inst;
  assign count_o           = count_q;
  assign ovf_o             = ovf_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Self-checking bench for alu_op_queue: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_alu_op_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] inst;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [2:0] count_o;
  logic       ovf_o;

  ent_t model[$];
  bit   mOvf;
  int   nCompared = 0;
  int   nMismatch = 0;

  alu_op_queue_if #(.DATA_W(8), .INST_W(3)) bus ();

  alu_op_queue #(.DATA_W(8), .INST_W(3), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  // Advance the model by the rules for one edge, then step the DUT and settle.
  task automatic cycle();
    bit full;
    full = (model.size() == DEPTH);
    if (rst_i) begin
      model.delete();
      mOvf = 1'b0;
    end else if (flush_i) begin
      model.delete();
    end else begin
      if (bus.in_valid_i && full) mOvf = 1'b1;
      if (bus.issue_ready_i && model.size() > 0) void'(model.pop_front());
      if (bus.in_valid_i && !full) model.push_back('{bus.in_a_i, bus.in_b_i, bus.in_inst_i});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] inst);
    bus.in_valid_i = 1'b1;
    bus.in_a_i     = a;
    bus.in_b_i     = b;
    bus.in_inst_i  = inst;
    cycle();
    bus.in_valid_i = 1'b0;
  endtask

  function automatic logic [7:0] expA();
    return (model.size() > 0) ? model[0].a : 8'd0;
  endfunction

  function automatic logic [7:0] expB();
    return (model.size() > 0) ? model[0].b : 8'd0;
  endfunction

  function automatic logic [2:0] expInst();
    return (model.size() > 0) ? model[0].inst : 3'd0;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0;
    bus.in_valid_i = 1'b0; bus.issue_ready_i = 1'b0;
    bus.in_a_i = '0; bus.in_b_i = '0; bus.in_inst_i = '0;
    cycle();
    cycle();
    rst_i = 1'b0;
    nCompared++;
    if (count_o !== 3'd0) begin nMismatch++; $display("[TB] FAIL reset_count: got %0d expected 0", count_o); end
    nCompared++;
    if (bus.issue_valid_o !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_issue_valid: got %b expected 0", bus.issue_valid_o); end
    nCompared++;
    if (bus.in_ready_o !== 1'b1) begin nMismatch++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready_o); end
    nCompared++;
    if (ovf_o !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_o); end
    nCompared++;
    if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== 19'd0) begin
      nMismatch++; $display("[TB] FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", bus.data_a_o, bus.data_b_o, bus.inst_o);
    end
  endtask

  task automatic test_single();
    drive_push(8'd25, 8'd35, 3'b011);
    nCompared++;
    if (bus.issue_valid_o !== 1'b1) begin nMismatch++; $display("[TB] FAIL single_valid: got %b expected 1", bus.issue_valid_o); end
    nCompared++;
    if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== {8'd25, 8'd35, 3'd3}) begin
      nMismatch++; $display("[TB] FAIL single_data: got %0d/%0d/%0d expected 25/35/3", bus.data_a_o, bus.data_b_o, bus.inst_o);
    end
    nCompared++;
    if (count_o !== 3'd1) begin nMismatch++; $display("[TB] FAIL single_count: got %0d expected 1", count_o); end
    bus.issue_ready_i = 1'b1;
    cycle();
    bus.issue_ready_i = 1'b0;
    nCompared++;
    if (count_o !== 3'd0 || bus.issue_valid_o !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL single_drain: got count %0d valid %b expected 0 0", count_o, bus.issue_valid_o);
    end
  endtask

  task automatic test_order();
    logic [7:0] ea [3] = '{8'd37, 8'd50, 8'd65};
    logic [7:0] eb [3] = '{8'd128, 8'd60, 8'd100};
    logic [2:0] ei [3] = '{3'd4, 3'd6, 3'd6};
    for (int i = 0; i < 3; i++) drive_push(ea[i], eb[i], ei[i]);
    nCompared++;
    if (count_o !== 3'd3) begin nMismatch++; $display("[TB] FAIL order_count: got %0d expected 3", count_o); end
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== {ea[i], eb[i], ei[i]}) begin
        nMismatch++; $display("[TB] FAIL order_head%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                              i, bus.data_a_o, bus.data_b_o, bus.inst_o, ea[i], eb[i], ei[i]);
      end
      bus.issue_ready_i = 1'b1;
      cycle();
      bus.issue_ready_i = 1'b0;
    end
    nCompared++;
    if (count_o !== 3'd0 || {bus.data_a_o, bus.data_b_o, bus.inst_o} !== 19'd0) begin
      nMismatch++; $display("[TB] FAIL order_empty: got count %0d data %0d/%0d/%0d expected 0 0/0/0",
                            count_o, bus.data_a_o, bus.data_b_o, bus.inst_o);
    end
  endtask

  task automatic test_full();
    logic [7:0] ea [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    logic [7:0] eb [4] = '{8'd201, 8'd202, 8'd203, 8'd204};
    logic [2:0] ei [4] = '{3'd0, 3'd1, 3'd5, 3'd7};
    for (int i = 0; i < 4; i++) drive_push(ea[i], eb[i], ei[i]);
    nCompared++;
    if (bus.in_ready_o !== 1'b0 || count_o !== 3'd4) begin
      nMismatch++; $display("[TB] FAIL full_state: got ready %b count %0d expected 0 4", bus.in_ready_o, count_o);
    end
    nCompared++;
    if (ovf_o !== 1'b0) begin nMismatch++; $display("[TB] FAIL full_ovf_early: got %b expected 0", ovf_o); end
    drive_push(8'd99, 8'd98, 3'd2);
    nCompared++;
    if (ovf_o !== 1'b1 || count_o !== 3'd4) begin
      nMismatch++; $display("[TB] FAIL full_ovf: got ovf %b count %0d expected 1 4", ovf_o, count_o);
    end
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== {ea[i], eb[i], ei[i]}) begin
        nMismatch++; $display("[TB] FAIL full_head%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                              i, bus.data_a_o, bus.data_b_o, bus.inst_o, ea[i], eb[i], ei[i]);
      end
      bus.issue_ready_i = 1'b1;
      cycle();
      bus.issue_ready_i = 1'b0;
    end
    nCompared++;
    if (count_o !== 3'd0 || bus.issue_valid_o !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL full_drain: got count %0d valid %b expected 0 0", count_o, bus.issue_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    drive_push(8'd1, 8'd2, 3'd3);
    drive_push(8'd4, 8'd5, 3'd6);
    for (int i = 0; i < 10; i++) begin
      nCompared++;
      if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== {expA(), expB(), expInst()}) begin
        nMismatch++; $display("[TB] FAIL b2b_head%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                              i, bus.data_a_o, bus.data_b_o, bus.inst_o, expA(), expB(), expInst());
      end
      bus.in_valid_i    = 1'b1;
      bus.in_a_i        = 8'($urandom_range(0, 255));
      bus.in_b_i        = 8'($urandom_range(0, 255));
      bus.in_inst_i     = 3'($urandom_range(0, 7));
      bus.issue_ready_i = 1'b1;
      cycle();
      nCompared++;
      if (count_o !== 3'd2) begin nMismatch++; $display("[TB] FAIL b2b_count%0d: got %0d expected 2", i, count_o); end
    end
    bus.in_valid_i = 1'b0;
    cycle();
    cycle();
    bus.issue_ready_i = 1'b0;
    nCompared++;
    if (count_o !== 3'd0) begin nMismatch++; $display("[TB] FAIL b2b_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_flush();
    drive_push(8'd7, 8'd8, 3'd1);
    drive_push(8'd9, 8'd10, 3'd2);
    drive_push(8'd11, 8'd12, 3'd3);
    flush_i = 1'b1;
    bus.in_valid_i = 1'b1; bus.in_a_i = 8'd77; bus.in_b_i = 8'd88; bus.in_inst_i = 3'd4;
    bus.issue_ready_i = 1'b1;
    cycle();
    flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.issue_ready_i = 1'b0;
    nCompared++;
    if (count_o !== 3'd0 || bus.issue_valid_o !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL flush_state: got count %0d valid %b expected 0 0", count_o, bus.issue_valid_o);
    end
    nCompared++;
    if (ovf_o !== mOvf) begin nMismatch++; $display("[TB] FAIL flush_ovf_kept: got %b expected %b", ovf_o, mOvf); end
  endtask

  task automatic test_reset_full();
    for (int i = 0; i < 5; i++) drive_push(8'(i + 100), 8'(i + 150), 3'(i));
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    nCompared++;
    if (count_o !== 3'd0 || ovf_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      nMismatch++; $display("[TB] FAIL rstfull_state: got count %0d ovf %b ready %b expected 0 0 1", count_o, ovf_o, bus.in_ready_o);
    end
    nCompared++;
    if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== 19'd0) begin
      nMismatch++; $display("[TB] FAIL rstfull_data: got %0d/%0d/%0d expected 0/0/0", bus.data_a_o, bus.data_b_o, bus.inst_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      flush_i           = ($urandom_range(0, 39) == 0);
      bus.in_valid_i    = !flush_i && ($urandom_range(0, 99) < 60);
      bus.issue_ready_i = ($urandom_range(0, 99) < 45);
      bus.in_a_i        = 8'($urandom_range(0, 255));
      bus.in_b_i        = 8'($urandom_range(0, 255));
      bus.in_inst_i     = 3'($urandom_range(0, 7));
      cycle();
      nCompared++;
      if (count_o !== 3'(model.size())) begin
        nMismatch++; $display("[TB] FAIL rand_count@%0d: got %0d expected %0d", i, count_o, model.size());
      end
      nCompared++;
      if (bus.issue_valid_o !== (model.size() > 0) || bus.in_ready_o !== (model.size() != DEPTH)) begin
        nMismatch++; $display("[TB] FAIL rand_flags@%0d: got valid %b ready %b expected %b %b", i,
                              bus.issue_valid_o, bus.in_ready_o, model.size() > 0, model.size() != DEPTH);
      end
      nCompared++;
      if (ovf_o !== mOvf) begin nMismatch++; $display("[TB] FAIL rand_ovf@%0d: got %b expected %b", i, ovf_o, mOvf); end
      nCompared++;
      if ({bus.data_a_o, bus.data_b_o, bus.inst_o} !== {expA(), expB(), expInst()}) begin
        nMismatch++; $display("[TB] FAIL rand_head@%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                              bus.data_a_o, bus.data_b_o, bus.inst_o, expA(), expB(), expInst());
      end
    end
    flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.issue_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
